// File: rtl/axi4_sram_responder.sv
// rtl/axi4_sram_responder.sv - AXI4 responder backed by a word-addressed register memory
// Optional WRAP burst support: define AXI4_SRAM_RESPONDER_WRAP_EN
module axi4_sram_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_awvalid,
  output logic                    o_awready,
  input  logic [ADDR_WIDTH-1:0]   i_awaddr,
  input  logic [ID_WIDTH-1:0]     i_awid,
  input  logic [7:0]              i_awlen,
  input  logic [2:0]              i_awsize,
  input  logic [1:0]              i_awburst,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_wlast,
  output logic                    o_bvalid,
  input  logic                    i_bready,
  output logic [ID_WIDTH-1:0]     o_bid,
  output logic [1:0]              o_bresp,
  output logic [USER_WIDTH-1:0]   o_buser,
  input  logic                    i_arvalid,
  output logic                    o_arready,
  input  logic [ADDR_WIDTH-1:0]   i_araddr,
  input  logic [ID_WIDTH-1:0]     i_arid,
  input  logic [7:0]              i_arlen,
  input  logic [2:0]              i_arsize,
  input  logic [1:0]              i_arburst,
  output logic                    o_rvalid,
  input  logic                    i_rready,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic [ID_WIDTH-1:0]     o_rid,
  output logic [1:0]              o_rresp,
  output logic                    o_rlast,
  output logic [USER_WIDTH-1:0]   o_ruser
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int BW = $clog2(NB);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(BW);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (AW + BW)) != '0;
  endfunction

  function automatic logic burst_bad(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] size,
                                     input logic [1:0] burst);
    return (size > MAX_SIZE) || (burst == 2'b11) || out_of_range(a);
  endfunction

  // mask selects the address bits that advance; all-ones makes WRAP behave as INCR
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
      input logic [2:0] size, input logic [1:0] burst, input logic [ADDR_WIDTH-1:0] mask);
    logic [ADDR_WIDTH-1:0] inc;
    inc = a + (ONE << size);
    case (burst)
      2'b00:   return a;
      2'b10:   return (a & ~mask) | (inc & mask);
      default: return inc;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  w_state_t w_state, w_next;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr, w_mask;
  logic [7:0]            w_len, w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_bad, w_slverr, aw_bad, aw_hs, w_hs, w_final, w_beat_err;

  r_state_t r_state, r_next_state;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr, r_mask, r_next;
  logic [7:0]            r_len, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_bad, r_last, ar_bad, ar_hs, r_hs, r_next_err;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;

`ifdef AXI4_SRAM_RESPONDER_WRAP_EN
  function automatic logic [ADDR_WIDTH-1:0] wrap_mask(input logic [7:0] len, input logic [2:0] size);
    return ((ADDR_WIDTH'(len) + ONE) << size) - ONE;
  endfunction

  function automatic logic wrap_bad(input logic [ADDR_WIDTH-1:0] a, input logic [7:0] len,
                                    input logic [2:0] size, input logic [1:0] burst);
    return (burst == 2'b10) &&
           (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) ||
            ((a & ((ONE << size) - ONE)) != '0));
  endfunction

  assign aw_bad = burst_bad(i_awaddr, i_awsize, i_awburst) || wrap_bad(i_awaddr, i_awlen, i_awsize, i_awburst);
  assign ar_bad = burst_bad(i_araddr, i_arsize, i_arburst) || wrap_bad(i_araddr, i_arlen, i_arsize, i_arburst);
  assign w_mask = wrap_mask(w_len, w_size);
  assign r_mask = wrap_mask(r_len, r_size);
`else
  assign aw_bad = burst_bad(i_awaddr, i_awsize, i_awburst);
  assign ar_bad = burst_bad(i_araddr, i_arsize, i_arburst);
  assign w_mask = '1;
  assign r_mask = '1;
`endif

  assign aw_hs      = i_awvalid && o_awready;
  assign w_hs       = i_wvalid && o_wready;
  assign w_final    = (w_cnt == w_len);
  assign w_beat_err = w_bad || out_of_range(w_addr);
  assign ar_hs      = i_arvalid && o_arready;
  assign r_hs       = o_rvalid && i_rready;
  assign r_next     = next_addr(r_addr, r_size, r_burst, r_mask);
  assign r_next_err = r_bad || out_of_range(r_next);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next_state;
    end
  end

  always_comb begin
    w_next       = w_state;
    r_next_state = r_state;
    o_awready    = 1'b0;
    o_wready     = 1'b0;
    o_bvalid     = 1'b0;
    o_arready    = 1'b0;
    o_rvalid     = 1'b0;
    case (w_state)
      W_IDLE: begin
        o_awready = 1'b1;
        if (i_awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        o_wready = 1'b1;
        if (i_wvalid && w_final) w_next = W_RESP;
      end
      default: begin
        o_bvalid = 1'b1;
        if (i_bready) w_next = W_IDLE;
      end
    endcase
    case (r_state)
      R_IDLE: begin
        o_arready = 1'b1;
        if (i_arvalid) r_next_state = R_DATA;
      end
      default: begin
        o_rvalid = 1'b1;
        if (i_rready && r_last) r_next_state = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      w_id <= '0; w_addr <= '0; w_len <= '0; w_size <= '0; w_burst <= '0;
      w_bad <= 1'b0; w_cnt <= '0; w_slverr <= 1'b0;
    end else if (aw_hs) begin
      w_id <= i_awid; w_addr <= i_awaddr; w_len <= i_awlen; w_size <= i_awsize;
      w_burst <= i_awburst; w_bad <= aw_bad; w_cnt <= '0; w_slverr <= 1'b0;
    end else if (w_hs) begin
      w_cnt  <= w_cnt + 8'd1;
      w_addr <= next_addr(w_addr, w_size, w_burst, w_mask);
      if (w_beat_err || (i_wlast != w_final)) w_slverr <= 1'b1;
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge i_clk) begin
    if (w_hs && !w_beat_err) begin
      for (int b = 0; b < NB; b++) begin
        if (i_wstrb[b]) mem[w_addr[AW+BW-1:BW]][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_id <= '0; r_addr <= '0; r_len <= '0; r_size <= '0; r_burst <= '0;
      r_bad <= 1'b0; r_cnt <= '0; r_data <= '0; r_resp <= 2'b00; r_last <= 1'b0;
    end else if (ar_hs) begin
      r_id <= i_arid; r_addr <= i_araddr; r_len <= i_arlen; r_size <= i_arsize;
      r_burst <= i_arburst; r_bad <= ar_bad; r_cnt <= '0;
      r_data <= ar_bad ? '0 : mem[i_araddr[AW+BW-1:BW]];
      r_resp <= ar_bad ? 2'b10 : 2'b00;
      r_last <= (i_arlen == 8'd0);
    end else if (r_hs) begin
      if (r_last) begin
        r_last <= 1'b0;
      end else begin
        r_addr <= r_next;
        r_cnt  <= r_cnt + 8'd1;
        r_data <= r_next_err ? '0 : mem[r_next[AW+BW-1:BW]];
        r_resp <= r_next_err ? 2'b10 : 2'b00;
        r_last <= ((r_cnt + 8'd1) == r_len);
      end
    end
  end

  assign o_bid   = w_id;
  assign o_bresp = w_slverr ? 2'b10 : 2'b00;
  assign o_buser = '0;
  assign o_rid   = r_id;
  assign o_rdata = r_data;
  assign o_rresp = r_resp;
  assign o_rlast = r_last;
  assign o_ruser = '0;
endmodule

// File: tb/tb_axi4_sram_responder.sv
// tb/tb_axi4_sram_responder.sv - directed self-checking bench for axi4_sram_responder
module tb_axi4_sram_responder;
  logic        i_clk = 1'b0, i_rst = 1'b1;
  logic        i_awvalid = 0, i_wvalid = 0, i_wlast = 0, i_bready = 0, i_arvalid = 0, i_rready = 0;
  logic [31:0] i_awaddr = 0, i_araddr = 0, i_wdata = 0;
  logic [7:0]  i_awid = 0, i_awlen = 0, i_arid = 0, i_arlen = 0;
  logic [2:0]  i_awsize = 0, i_arsize = 0;
  logic [1:0]  i_awburst = 0, i_arburst = 0;
  logic [3:0]  i_wstrb = 0;
  logic        o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_rlast;
  logic [7:0]  o_bid, o_rid, o_buser, o_ruser;
  logic [1:0]  o_bresp, o_rresp;
  logic [31:0] o_rdata;

  int checks = 0, errors = 0;
  logic [31:0] wdat[16], edat[16];
  logic [3:0]  wstb[16];
  logic [1:0]  ersp[16];
  logic [31:0] held;

  axi4_sram_responder dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awaddr(i_awaddr), .i_awid(i_awid),
    .i_awlen(i_awlen), .i_awsize(i_awsize), .i_awburst(i_awburst),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast),
    .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bid(o_bid), .o_bresp(o_bresp), .o_buser(o_buser),
    .i_arvalid(i_arvalid), .o_arready(o_arready), .i_araddr(i_araddr), .i_arid(i_arid),
    .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arburst(i_arburst),
    .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rdata(o_rdata), .o_rid(o_rid),
    .o_rresp(o_rresp), .o_rlast(o_rlast), .o_ruser(o_ruser)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst, input int bad_last,
                    input int bdelay, input logic [1:0] eresp, input string tag);
    i_awvalid = 1; i_awid = id; i_awaddr = addr; i_awlen = len; i_awsize = size; i_awburst = burst;
    check({tag, " awready"}, o_awready, 1);
    tick();
    i_awvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      i_wvalid = 1; i_wdata = wdat[i]; i_wstrb = wstb[i];
      i_wlast = (i == int'(len)) ^ (i == bad_last);
      check($sformatf("%s wready%0d", tag, i), o_wready, 1);
      tick();
    end
    i_wvalid = 0; i_wlast = 0;
    for (int d = 0; d < bdelay; d++) begin
      check($sformatf("%s bhold%0d", tag, d), {o_bvalid, o_awready}, 2'b10);
      tick();
    end
    check({tag, " bvalid"}, o_bvalid, 1);
    check({tag, " bid"}, o_bid, id);
    check({tag, " bresp"}, o_bresp, eresp);
    i_bready = 1;
    tick();
    i_bready = 0;
    check({tag, " bdone"}, {o_bvalid, o_awready}, 2'b01);
  endtask

  task automatic rd(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst, input bit toggle, input string tag);
    i_arvalid = 1; i_arid = id; i_araddr = addr; i_arlen = len; i_arsize = size; i_arburst = burst;
    check({tag, " arready"}, o_arready, 1);
    tick();
    i_arvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      check($sformatf("%s rvalid%0d", tag, i), o_rvalid, 1);
      check($sformatf("%s rdata%0d", tag, i), o_rdata, edat[i]);
      check($sformatf("%s rresp%0d", tag, i), o_rresp, ersp[i]);
      check($sformatf("%s rlast%0d", tag, i), o_rlast, (i == int'(len)));
      check($sformatf("%s rid%0d", tag, i), o_rid, id);
      if (toggle) begin
        i_rready = 0;
        tick();
        check($sformatf("%s stall%0d", tag, i), {o_rvalid, o_rlast, o_rdata},
              {1'b1, (i == int'(len)), edat[i]});
      end
      i_rready = 1;
      tick();
    end
    i_rready = 0;
    check({tag, " ridle"}, {o_rvalid, o_arready}, 2'b01);
  endtask

  initial begin
    tick();
    check("reset ready", {o_awready, o_arready, o_wready, o_bvalid, o_rvalid, o_rlast}, 6'b110000);
    check("reset resp", {o_bresp, o_rresp, o_bid, o_rid}, 0);
    check("reset rdata", o_rdata, 0);
    i_rst = 0;
    tick();

    for (int i = 0; i < 4; i++) begin wdat[i] = 32'hA0 + i; wstb[i] = 4'hF; edat[i] = 32'hA0 + i; ersp[i] = 0; end
    wr(8'd3, 32'h10, 8'd3, 3'd2, 2'b01, -1, 0, 2'b00, "t1w");
    rd(8'd5, 32'h10, 8'd3, 3'd2, 2'b01, 0, "t1r");

    wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
    wr(8'd1, 32'h20, 8'd0, 3'd2, 2'b01, -1, 0, 2'b00, "t2init");
    wdat[0] = 32'h11223344; wstb[0] = 4'h1; wdat[1] = 32'h55667788; wstb[1] = 4'h2;
    wr(8'd2, 32'h20, 8'd1, 3'd2, 2'b00, -1, 0, 2'b00, "t2fixw");
    edat[0] = 32'hDEAD7744; ersp[0] = 0;
    rd(8'd6, 32'h20, 8'd0, 3'd2, 2'b01, 0, "t2r");
    edat[0] = 32'hA0; edat[1] = 32'hA0; ersp[1] = 0;
    rd(8'd6, 32'h10, 8'd1, 3'd2, 2'b00, 0, "t2fixr");

    wdat[0] = 32'h12345678; wstb[0] = 4'hF;
    wr(8'd0, 32'h0, 8'd0, 3'd2, 2'b01, -1, 0, 2'b00, "t3w0");
    edat[0] = 0; edat[1] = 0; ersp[0] = 2'b10; ersp[1] = 2'b10;
    rd(8'd7, 32'h400, 8'd1, 3'd2, 2'b01, 0, "t3oor_r");
    wdat[0] = 32'hBADBAD00;
    wr(8'd4, 32'h400, 8'd0, 3'd2, 2'b01, -1, 0, 2'b10, "t3oor_w");
    edat[0] = 32'h12345678; ersp[0] = 0;
    rd(8'd7, 32'h0, 8'd0, 3'd2, 2'b01, 0, "t3untouched");
    wdat[0] = 32'hFACE0001; wdat[1] = 32'hFACE0002; wstb[1] = 4'hF;
    wr(8'd4, 32'h3FC, 8'd1, 3'd2, 2'b01, -1, 0, 2'b10, "t3edge_w");
    edat[0] = 32'hFACE0001; ersp[0] = 0; edat[1] = 0; ersp[1] = 2'b10;
    rd(8'd7, 32'h3FC, 8'd1, 3'd2, 2'b01, 0, "t3edge_r");
    edat[0] = 0; ersp[0] = 2'b10;
    rd(8'd7, 32'h10, 8'd0, 3'd2, 2'b11, 0, "t3rsvd");
    rd(8'd7, 32'h10, 8'd0, 3'd3, 2'b01, 0, "t3size");
    wdat[0] = 32'h77; wdat[1] = 32'h88;
    wr(8'd4, 32'h28, 8'd1, 3'd2, 2'b01, 0, 0, 2'b10, "t3wlast");
    edat[0] = 32'h77; edat[1] = 32'h88; ersp[0] = 0; ersp[1] = 0;
    rd(8'd7, 32'h28, 8'd1, 3'd2, 2'b01, 0, "t3wlast_r");

    for (int i = 0; i < 8; i++) begin wdat[i] = 32'hC0 + i; wstb[i] = 4'hF; edat[i] = 32'hC0 + i; ersp[i] = 0; end
    wr(8'd9, 32'h40, 8'd7, 3'd2, 2'b01, -1, 5, 2'b00, "t4w");
    rd(8'd9, 32'h40, 8'd7, 3'd2, 2'b01, 1, "t4r");

    // Overlapped write to 0x60 and read of 0x40
    i_awvalid = 1; i_awid = 8'd7; i_awaddr = 32'h60; i_awlen = 8'd3; i_awsize = 3'd2; i_awburst = 2'b01;
    tick();
    i_awvalid = 0; i_rready = 1;
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        i_wvalid = 1; i_wdata = 32'hD0 + k; i_wstrb = 4'hF; i_wlast = (k == 3);
        check($sformatf("t5 wready%0d", k), o_wready, 1);
      end else begin
        i_wvalid = 0; i_wlast = 0;
      end
      if (k == 0) begin
        i_arvalid = 1; i_arid = 8'd8; i_araddr = 32'h40; i_arlen = 8'd3; i_arsize = 3'd2; i_arburst = 2'b01;
        check("t5 arready", o_arready, 1);
      end else begin
        i_arvalid = 0;
      end
      if (k >= 1) check($sformatf("t5 rbeat%0d", k - 1), {o_rvalid, o_rlast, o_rdata}, {1'b1, (k == 4), 32'hC0 + k - 1});
      tick();
    end
    i_rready = 0;
    check("t5 rdone", o_rvalid, 0);
    check("t5 b", {o_bvalid, o_bid, o_bresp}, {1'b1, 8'd7, 2'b00});
    i_bready = 1; tick(); i_bready = 0;
    for (int i = 0; i < 4; i++) begin edat[i] = 32'hD0 + i; ersp[i] = 0; end
    rd(8'd2, 32'h60, 8'd3, 3'd2, 2'b01, 0, "t5rb");

    // Same-word read and write in the same cycle: read sees the old word
    i_awvalid = 1; i_awid = 8'h0A; i_awaddr = 32'h60; i_awlen = 0; i_awsize = 3'd2; i_awburst = 2'b01;
    tick();
    i_awvalid = 0;
    i_wvalid = 1; i_wdata = 32'hE0; i_wstrb = 4'hF; i_wlast = 1;
    i_arvalid = 1; i_arid = 8'h0B; i_araddr = 32'h60; i_arlen = 0; i_arsize = 3'd2; i_arburst = 2'b01;
    tick();
    i_wvalid = 0; i_wlast = 0; i_arvalid = 0;
    check("t5 raw old", {o_rvalid, o_rdata}, {1'b1, 32'hD0});
    check("t5 raw b", o_bvalid, 1);
    i_rready = 1; i_bready = 1; tick(); i_rready = 0; i_bready = 0;
    edat[0] = 32'hE0;
    rd(8'd2, 32'h60, 8'd0, 3'd2, 2'b01, 0, "t5raw_new");

    for (int i = 0; i < 4; i++) begin wdat[i] = 32'hB0 + i; wstb[i] = 4'hF; ersp[i] = 0; end
    wr(8'd1, 32'h30, 8'd3, 3'd2, 2'b01, -1, 0, 2'b00, "t6w");
    edat[0] = 32'hB2; edat[1] = 32'hB3;
`ifdef AXI4_SRAM_RESPONDER_WRAP_EN
    edat[2] = 32'hB0; edat[3] = 32'hB1;
`else
    edat[2] = 32'hC0; edat[3] = 32'hC1;
`endif
    rd(8'd3, 32'h38, 8'd3, 3'd2, 2'b10, 0, "t6wrap");

    // Asynchronous reset in the middle of a read burst
    i_arvalid = 1; i_arid = 8'd1; i_araddr = 32'h40; i_arlen = 8'd7; i_arsize = 3'd2; i_arburst = 2'b01;
    tick();
    i_arvalid = 0; i_rready = 1;
    tick(); tick();
    check("t5 pre-rst", {o_rvalid, o_rdata}, {1'b1, 32'hC2});
    i_rst = 1;
    #1;
    check("t5 async rst", {o_rvalid, o_rlast, o_arready}, 3'b001);
    i_rready = 0;
    tick();
    i_rst = 0;
    tick();
    check("t5 post-rst", {o_arready, o_awready, o_rvalid, o_bvalid, o_wready}, 5'b11000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi4_sram_responder.md
Name: axi4_sram_responder

Overview:
- AXI4 slave (responder) that backs a full AXI4 interface with an internal word-addressed register memory.
- Serves real INCR/FIXED bursts on independent write and read paths.
- Placed at the slave end of the std axi4 interface, opposite an AXI4 master. Replaces the all-zero tie-off responder in subsystem tests and in small on-chip scratchpads.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width; power of 2, minimum 8
ID_WIDTH, 8, AXI ID width for aw/b/ar/r
USER_WIDTH, 8, user-signal width; buser/ruser driven 0
DEPTH, 256, memory words; power of 2; AW = log2(DEPTH), BW = log2(DATA_WIDTH/8)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous reset, active-high
i_awvalid/o_awready, i_awaddr[ADDR_WIDTH], i_awid[ID_WIDTH], i_awlen[8], i_awsize[3], i_awburst[2]  AW channel (awlock/cache/prot/qos/region/user accepted, ignored)
i_wvalid/o_wready, i_wdata[DATA_WIDTH], i_wstrb[DATA_WIDTH/8], i_wlast  W channel
o_bvalid/i_bready, o_bid[ID_WIDTH], o_bresp[2], o_buser[USER_WIDTH]  B channel
i_arvalid/o_arready, i_araddr, i_arid, i_arlen[8], i_arsize[3], i_arburst[2]  AR channel (other ar fields ignored)
o_rvalid/i_rready, o_rdata[DATA_WIDTH], o_rid, o_rresp[2], o_rlast, o_ruser  R channel

Behaviour:
- Reset (asynchronous, i_rst=1): both FSMs go to IDLE. awready=arready=1; wready=bvalid=rvalid=rlast=0; bresp=rresp=OKAY; bid/rid/rdata=0.
- Memory contents are not reset.
- Reset mid-burst aborts the burst silently, with no response issued.
- Write FSM: W_IDLE -> W_DATA on AW handshake. Latches id, addr, len, size, burst; clears error flag; beat count=0.
- W_DATA: wready=1. Each W handshake writes the bytes enabled by wstrb to mem[addr[AW+BW-1:BW]], increments the count and advances addr.
- The burst ends after beat count == awlen+1, independent of wlast. W_DATA -> W_RESP.
- W_RESP: bvalid=1, bid=latched id. Held until bready; then -> W_IDLE.
- awready=1 only in W_IDLE. Exactly one write is outstanding.
- Read FSM: R_IDLE -> R_DATA on AR handshake. The first rvalid is asserted the next cycle, so latency is 1.
- rdata is registered from memory at the current address. The next beat loads on each R handshake, so back-to-back beats go out at 1/cycle.
- rlast=1 on beat arlen+1. The R handshake on that beat -> R_IDLE. arready=1 only in R_IDLE.
- Address advance:
  - FIXED (00): address held.
  - INCR (01): addr += 2^size, full ADDR_WIDTH add, no 4KB check.
  - WRAP (10): treated as INCR when the feature is off.
  - Reserved (11): SLVERR.
- SLVERR (resp=2'b10) for the whole burst if size > BW, burst=11, or the starting address has nonzero bits above AW+BW.
- A beat whose advanced address leaves the memory range gets SLVERR for that beat.
- Errored write beats do not update memory. Errored read beats return rdata=0.
- wlast mismatch (wlast=1 before the final beat, or 0 on the final beat) sets bresp=SLVERR; data is still written.
- Write and read in the same cycle to the same word: the read beat loads the old data; the write is visible from the next load.
- Valids, once asserted, are held with stable payload until their handshake.

Optional Feature:
- Macro AXI4_SRAM_RESPONDER_WRAP_EN.
- Defined: WRAP bursts are supported. wrap_bytes = (len+1)<<size, where len+1 must be 2/4/8/16 and the start address must be aligned to 2^size; otherwise SLVERR. The address wraps within the aligned wrap_bytes boundary.
- Undefined: WRAP is handled exactly as INCR with OKAY response.

Test Plan:
1. Reset, then INCR write id=3, addr=0x10, len=3, size=2, data 0xA0..0xA3, wstrb=F -> one bvalid, bid=3, bresp=OKAY. Read of the same region returns A0,A1,A2,A3, rlast on the 4th beat, rid matches.
2. FIXED write len=1 to 0x20 with wstrb=0x1 then 0x2, data 0x11223344 then 0x55667788; later read -> word 0x20 low bytes = 0x????7744 with upper bytes unchanged. rresp=OKAY.
3. Read at addr=0x400 with DEPTH=256, DATA_WIDTH=32 -> each beat rresp=SLVERR, rdata=0. Write there -> bresp=SLVERR, memory untouched.
4. rready toggled 1/0 every cycle during a len=7 read -> rdata/rlast stable while stalled, 8 beats in order. bready held low 5 cycles -> bvalid held, awready=0 throughout.
5. Overlapping streams: AR accepted during a W_DATA burst -> both complete, throughput 1 beat/cycle each. Assert i_rst mid-read -> rvalid=0 immediately (asynchronous), arready=1 after release.
6. With WRAP_EN: WRAP len=3, size=2, addr=0x38 -> beats hit 0x38, 0x3C, 0x30, 0x34. Without WRAP_EN -> beats hit 0x38, 0x3C, 0x40, 0x44.
